sipo_rx: RTL and testbench
==========================

# sipo_rx

Serial-in, parallel-out receiver: the far end of a serial link whose parallel words are latched by the team's 4-bit parallel registers. Shifts qualified serial bits into a WIDTH-bit word, presents it with its bitwise complement on a valid/ready output handshake, and flags words lost to back-pressure. Optionally checks an even-parity bit that trails each word.

## Interface
- WIDTH, 4, data bits per word (≥2)
- MSB_FIRST, 1, 1: first received bit lands in q[WIDTH-1]; 0: first bit lands in q[0]
- clk  in  1  single clock, all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- sin  in  1  serial data bit
- sin_en  in  1  sin qualifier; a bit is consumed only on an edge with sin_en=1
- clear  in  1  synchronous flush of the partial word and overrun flag
- q  out  WIDTH  received word
- qb  out  WIDTH  always ~q
- out_valid  out  1  q/qb/out_perr hold an unaccepted word
- out_ready  in  1  consumer accepts the word on an edge with out_valid=1
- out_perr  out  1  parity error for the word in q
- busy  out  1  partial word in progress (bit count ≠ 0 or in parity phase)
- overrun  out  1  sticky: a completed word was dropped

## Operation
- States: ST_DATA (collect WIDTH bits), ST_PARITY (collect one parity bit, only with PARITY_CHECK_EN).
- ST_DATA: each qualified bit shifts in and increments bit_cnt (0..WIDTH-1). On the WIDTH-th bit: with parity, go to ST_PARITY; without, complete the word and return bit_cnt to 0.
- ST_PARITY: the qualified bit completes the word; out_perr = XOR(data, parity bit) (even parity: 1 means error). Return to ST_DATA with bit_cnt=0.
- Completion with out_valid=0, or with out_valid=1 and out_ready=1 on the same edge: load q, qb=~q, out_perr; out_valid=1.
- Completion with out_valid=1 and out_ready=0: drop the new word, hold q/qb/out_perr/out_valid, set overrun.
- Accept without completion (out_valid & out_ready): out_valid→0 next edge; q retains its value.
- clear: bit_cnt←0, shift register←0, state←ST_DATA, overrun←0; q, qb, out_valid, out_perr untouched. A bit qualified on the same edge as clear is discarded. A completion on the same edge is suppressed.
- Priority: rst_n > clear > bit reception.

## Timing
- Reset values: q=0, qb=all ones, out_valid=0, out_perr=0, busy=0, overrun=0, state ST_DATA, bit_cnt=0.
- Latency: q/out_valid update on the same posedge that samples the final bit (data or parity); both are visible in the following cycle.
- Throughput: one word per WIDTH (or WIDTH+1) qualified bits; back-to-back words need no gap cycles.
- sin_en may drop for any number of cycles mid-word; the state holds.
- rst_n low mid-word discards the partial word; the first bit after reset is bit 0 of a new word.
- All outputs are registered. qb is never combinationally derived from an input.

## Configuration
- PARITY_CHECK_EN defined: ST_PARITY present; each frame is WIDTH+1 bits; out_perr is computed per word.
- Undefined: frame is WIDTH bits; there is no ST_PARITY logic; out_perr is tied to 0. The port remains so the interface is unchanged.

## Structure
- Package sipo_pkg: state enum (ST_DATA, ST_PARITY), bit-count width function clog2(WIDTH), default WIDTH constant.
- One sub-module, sipo_shreg: WIDTH-bit shift register with enable, synchronous clear, and direction set by MSB_FIRST. sipo_rx owns the FSM, counter, handshake and flags.

## Test plan
- Reset, then send 1,0,1,1 (WIDTH=4, MSB_FIRST=1, sin_en=1, out_ready=1) → q=4'b1011, qb=4'b0100, out_valid high for one cycle after the 4th bit edge.
- Same bits with MSB_FIRST=0 → q=4'b1101. Insert 3 idle cycles with sin_en=0 after bit 2; the result is unchanged.
- out_ready=0; send word 4'hA, then word 4'h5 → q stays 4'hA, overrun=1. Pulse clear → overrun=0, q still 4'hA.
- out_ready=1 on the same edge that completes a second word → first word accepted, q=second word, out_valid stays 1, overrun=0.
- Assert rst_n=0 after 2 bits of a word, release, then send 0,1,1,0 → q=4'b0110, busy=0 after completion.
- PARITY_CHECK_EN: data 4'b1011 with parity 1 → out_perr=0; with parity 0 → out_perr=1 and the word is still delivered.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in, parallel-out receiver: FSM state
// encodings, default word width and the bit-counter width helper.
package sipo_pkg;

    localparam int unsigned SIPO_WIDTH_DEFAULT = 4;

    // Frame phase: collecting data bits, or waiting for the trailing parity bit
    localparam logic [0:0] ST_DATA   = 1'b0;
    localparam logic [0:0] ST_PARITY = 1'b1;

    // Bits needed to count 0..value-1; never less than one bit
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/sipo_shreg.sv
// WIDTH-bit shift register with enable and synchronous clear. MSB_FIRST=1
// shifts towards the MSB so the first bit ends up in q[WIDTH-1]; MSB_FIRST=0
// shifts towards the LSB so the first bit ends up in q[0].
module sipo_shreg #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next
);

    // Value the register takes if the current bit is shifted in
    always_comb begin
        q_next = q;
        if (MSB_FIRST) begin
            q_next = {q[WIDTH-2:0], din};
        end else begin
            q_next = {din, q[WIDTH-1:1]};
        end
    end

    // Clear wins over shifting
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in, parallel-out receiver with valid/ready output handshake and a
// sticky overrun flag. Define PARITY_CHECK_EN to expect an even-parity bit
// after each data word; otherwise out_perr is tied low.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = SIPO_WIDTH_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_perr,
    output logic             busy,
    output logic             overrun
);

    localparam int unsigned CW = clog2(WIDTH);

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_next;
    logic [WIDTH-1:0] word_in;
    logic             take;
    logic             last_bit;
    logic             complete;
    logic             sh_en;

    // A bit arriving together with clear is discarded
    assign take     = sin_en && !clear;
    assign last_bit = (bit_cnt == CW'(WIDTH - 1));

    sipo_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk    (clk),
        .clr    (!rst_n || clear),
        .en     (sh_en),
        .din    (sin),
        .q      (sh_q),
        .q_next (sh_next)
    );

`ifdef PARITY_CHECK_EN
    logic [0:0] state;
    logic       perr_in;
    logic       perr_q;

    // Data is complete in the register once the parity bit arrives
    assign sh_en    = take && (state == ST_DATA);
    assign complete = take && (state == ST_PARITY);
    assign word_in  = sh_q;
    assign perr_in  = (^sh_q) ^ sin;
    assign busy     = (bit_cnt != '0) || (state == ST_PARITY);
    assign out_perr = perr_q;

    // Frame sequencing: WIDTH data bits then one parity bit
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            bit_cnt <= '0;
            state   <= ST_DATA;
        end else if (take) begin
            if (state == ST_PARITY) begin
                state <= ST_DATA;
            end else if (last_bit) begin
                bit_cnt <= '0;
                state   <= ST_PARITY;
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end
`else
    logic unused_sh_q;

    // Word completes on the last data bit, so load the shifted-in value
    assign sh_en       = take;
    assign complete    = take && last_bit;
    assign word_in     = sh_next;
    assign busy        = (bit_cnt != '0);
    assign out_perr    = 1'b0;
    assign unused_sh_q = ^sh_q;

    // Data bit counter wraps at WIDTH
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            bit_cnt <= '0;
        end else if (take) begin
            bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
        end
    end
`endif

    // Output word, handshake and overrun; a completion into a stalled slot is dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q         <= '0;
            qb        <= '1;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            if (clear) begin
                overrun <= 1'b0;
            end
            if (complete) begin
                if (!out_valid || out_ready) begin
                    q         <= word_in;
                    qb        <= ~word_in;
                    out_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
                    perr_q    <= perr_in;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: one MSB-first and one LSB-first instance share
// the same serial stimulus. Works with or without PARITY_CHECK_EN.
module tb_sipo_rx;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sin;
    logic         sin_en;
    logic         clear;
    logic         out_ready;

    logic [W-1:0] q_m, qb_m, q_l, qb_l;
    logic         v_m, perr_m, busy_m, ovr_m;
    logic         v_l, perr_l, busy_l, ovr_l;

    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    sipo_rx #(
        .WIDTH     (W),
        .MSB_FIRST (1'b1)
    ) u_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .sin_en    (sin_en),
        .clear     (clear),
        .q         (q_m),
        .qb        (qb_m),
        .out_valid (v_m),
        .out_ready (out_ready),
        .out_perr  (perr_m),
        .busy      (busy_m),
        .overrun   (ovr_m)
    );

    sipo_rx #(
        .WIDTH     (W),
        .MSB_FIRST (1'b0)
    ) u_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .sin_en    (sin_en),
        .clear     (clear),
        .q         (q_l),
        .qb        (qb_l),
        .out_valid (v_l),
        .out_ready (out_ready),
        .out_perr  (perr_l),
        .busy      (busy_l),
        .overrun   (ovr_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; presents one qualified bit for the next posedge
    task automatic bit_in(input logic b);
        sin    = b;
        sin_en = 1'b1;
        @(negedge clk);
        sin_en = 1'b0;
        sin    = 1'b0;
    endtask

    // Sends w[3] first; out_ready takes rdy_last for the completing edge
    task automatic send_word(input logic [3:0] w, input logic rdy_last);
        bit_in(w[3]);
        bit_in(w[2]);
        bit_in(w[1]);
`ifdef PARITY_CHECK_EN
        bit_in(w[0]);
        out_ready = rdy_last;
        bit_in(^w);
`else
        out_ready = rdy_last;
        bit_in(w[0]);
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        sin       = 1'b0;
        sin_en    = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_q",     q_m,    4'h0);
        check("rst_qb",    qb_m,   4'hF);
        check("rst_valid", v_m,    1'b0);
        check("rst_busy",  busy_m, 1'b0);
        check("rst_ovr",   ovr_m,  1'b0);
        check("rst_perr",  perr_m, 1'b0);
        rst_n = 1'b1;

        // Basic word 1,0,1,1
        send_word(4'b1011, 1'b1);
        check("t1_q_msb",   q_m,    4'b1011);
        check("t1_qb_msb",  qb_m,   4'b0100);
        check("t1_valid",   v_m,    1'b1);
        check("t1_busy",    busy_m, 1'b0);
        check("t1_q_lsb",   q_l,    4'b1101);
        check("t1_qb_lsb",  qb_l,   4'b0010);
        check("t1_perr",    perr_m, 1'b0);
        @(negedge clk);
        check("t1_accept",  v_m,    1'b0);
        check("t1_q_hold",  q_m,    4'b1011);

        // Same word with a 3-cycle sin_en gap after bit 2
        bit_in(1'b1);
        bit_in(1'b0);
        check("t2_busy_mid", busy_m, 1'b1);
        repeat (3) @(negedge clk);
        check("t2_busy_gap", busy_l, 1'b1);
        bit_in(1'b1);
        bit_in(1'b1);
`ifdef PARITY_CHECK_EN
        bit_in(1'b1);
`endif
        check("t2_q_lsb",   q_l,    4'b1101);
        check("t2_q_msb",   q_m,    4'b1011);
        check("t2_valid",   v_l,    1'b1);
        @(negedge clk);

        // Back-pressure: second word dropped, overrun set
        out_ready = 1'b0;
        send_word(4'hA, 1'b0);
        check("t3_q_a",     q_m,    4'hA);
        check("t3_q_a_lsb", q_l,    4'h5);
        check("t3_valid_a", v_m,    1'b1);
        send_word(4'h5, 1'b0);
        check("t3_q_hold",  q_m,    4'hA);
        check("t3_ql_hold", q_l,    4'h5);
        check("t3_ovr",     ovr_m,  1'b1);
        check("t3_ovr_lsb", ovr_l,  1'b1);
        check("t3_valid",   v_m,    1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t3_clr_ovr", ovr_m,  1'b0);
        check("t3_clr_q",   q_m,    4'hA);
        check("t3_clr_v",   v_m,    1'b1);

        // Accept on the same edge as the next completion
        send_word(4'h3, 1'b1);
        check("t4_q",       q_m,    4'h3);
        check("t4_q_lsb",   q_l,    4'hC);
        check("t4_valid",   v_m,    1'b1);
        check("t4_ovr",     ovr_m,  1'b0);
        @(negedge clk);
        check("t4_drain",   v_m,    1'b0);

        // Clear mid-word, with a qualified bit on the clear edge
        bit_in(1'b1);
        bit_in(1'b1);
        sin    = 1'b1;
        sin_en = 1'b1;
        clear  = 1'b1;
        @(negedge clk);
        clear  = 1'b0;
        sin_en = 1'b0;
        check("t5_clr_busy", busy_m, 1'b0);
        send_word(4'hC, 1'b1);
        check("t5_q",       q_m,    4'hC);
        check("t5_q_lsb",   q_l,    4'h3);
        @(negedge clk);

        // Reset mid-word
        bit_in(1'b1);
        bit_in(1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_busy", busy_m, 1'b0);
        check("t6_rst_q",    q_m,    4'h0);
        check("t6_rst_qb",   qb_m,   4'hF);
        rst_n = 1'b1;
        send_word(4'b0110, 1'b1);
        check("t6_q",       q_m,    4'b0110);
        check("t6_q_lsb",   q_l,    4'b0110);
        check("t6_busy",    busy_m, 1'b0);
        check("t6_valid",   v_m,    1'b1);
        @(negedge clk);

`ifdef PARITY_CHECK_EN
        // Parity: good then bad trailer on 4'b1011
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b1);
        check("t7_busy_par", busy_m, 1'b1);
        bit_in(1'b1);
        check("t7_perr_ok", perr_m, 1'b0);
        check("t7_q_ok",    q_m,    4'b1011);
        @(negedge clk);
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b0);
        check("t7_perr_bad", perr_m, 1'b1);
        check("t7_v_bad",    v_m,    1'b1);
        check("t7_q_bad",    q_m,    4'b1011);
        @(negedge clk);
`else
        check("t7_perr_tied", perr_l, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
